counter_updown_param: RTL and testbench

Parametrised successor to the team's fixed 8-bit enable counter. It adds:
- configurable width and modulus
- up/down direction
- synchronous load
- a wrap or saturate mode
- a terminal-count flag and a sticky overflow flag

It is used as a generic event/timebase counter in datapath and control blocks, in place of fixed-width enable counters.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/counter_next_value.sv | 65 ++++++
 rtl/counter_updown_param.sv | 73 +++++++
 tb/tb_counter_updown_param.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    // Limit behaviour selection for the SATURATE parameter.
    localparam int unsigned CNT_MODE_WRAP = 0;
    localparam int unsigned CNT_MODE_SAT  = 1;

    // Encoding of the up_dn input.
    localparam logic CNT_DIR_DOWN = 1'b0;
    localparam logic CNT_DIR_UP   = 1'b1;

    // Ceiling log2, usable in constant expressions; clog2(1) == 0.
    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned     result;
        longint unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_next_value.sv
// Combinational next-state and terminal-count logic for counter_updown_param.
module counter_next_value
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up_dn,
    input  logic             i_count_enb,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_next_count,
    output logic             o_tc
);

    // One extra bit so MODULUS == 2**WIDTH still yields a representable limit.
    localparam logic [WIDTH:0]   MaxValExt = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] MaxVal    = MaxValExt[WIDTH-1:0];

    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_count_ext = {1'b0, i_count};
    assign w_load_ext  = {1'b0, i_load_value};
    assign w_inc       = i_count + WIDTH'(1);
    assign w_dec       = i_count - WIDTH'(1);
    assign w_at_max    = (w_count_ext >= MaxValExt);
    assign w_at_zero   = (i_count == '0);

    // Select next count by priority load > count step > hold; flag steps taken at a limit.
    always_comb begin
        o_next_count = i_count;
        o_tc         = 1'b0;
        if (i_load) begin
            if (w_load_ext > MaxValExt) begin
                o_next_count = MaxVal;
            end else begin
                o_next_count = i_load_value;
            end
        end else if (i_count_enb) begin
            if (i_up_dn == CNT_DIR_UP) begin
                if (w_at_max) begin
                    o_tc         = 1'b1;
                    o_next_count = (SATURATE == CNT_MODE_SAT) ? MaxVal : '0;
                end else begin
                    o_next_count = w_inc;
                end
            end else begin
                if (w_at_zero) begin
                    o_tc         = 1'b1;
                    o_next_count = (SATURATE == CNT_MODE_SAT) ? '0 : MaxVal;
                end else begin
                    o_next_count = w_dec;
                end
            end
        end
    end

endmodule

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with load, wrap/saturate limits, tc and sticky ovf.
module counter_updown_param
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter longint unsigned MODULUS     = 256,
    parameter int unsigned     SATURATE    = CNT_MODE_WRAP,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_enb,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ResetCount = WIDTH'(RESET_VALUE);

    // Reject configurations that would let count escape 0..MODULUS-1.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_updown_param: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
        $error("counter_updown_param: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
        $error("counter_updown_param: RESET_VALUE must be below MODULUS");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next_count;
    logic             w_tc;

    counter_next_value #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .i_count      (r_count),
        .i_up_dn      (up_dn),
        .i_count_enb  (count_enb),
        .i_load       (load),
        .i_load_value (load_value),
        .o_next_count (w_next_count),
        .o_tc         (w_tc)
    );

    // Count and sticky overflow registers; a limit step sets ovf even if ovf_clr is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= ResetCount;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            if (w_tc) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;
    assign tc    = w_tc & reset;

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed self-checking bench for counter_updown_param across four configurations.
module tb_counter_updown_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       count_enb;
    logic       up_dn;
    logic       load;
    logic [7:0] load_value;
    logic       ovf_clr;

    logic [7:0] count_def, count_sat, count_rst;
    logic [3:0] count_mod;
    logic       tc_def, tc_mod, tc_sat, tc_rst;
    logic       ovf_def, ovf_mod, ovf_sat, ovf_rst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_updown_param #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .RESET_VALUE(0)) u_def (
        .clk(clk), .reset(reset), .count_enb(count_enb), .up_dn(up_dn), .load(load),
        .load_value(load_value), .ovf_clr(ovf_clr), .count(count_def), .tc(tc_def), .ovf(ovf_def)
    );

    counter_updown_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VALUE(0)) u_mod (
        .clk(clk), .reset(reset), .count_enb(count_enb), .up_dn(up_dn), .load(load),
        .load_value(load_value[3:0]), .ovf_clr(ovf_clr), .count(count_mod), .tc(tc_mod),
        .ovf(ovf_mod)
    );

    counter_updown_param #(.WIDTH(8), .MODULUS(256), .SATURATE(1), .RESET_VALUE(0)) u_sat (
        .clk(clk), .reset(reset), .count_enb(count_enb), .up_dn(up_dn), .load(load),
        .load_value(load_value), .ovf_clr(ovf_clr), .count(count_sat), .tc(tc_sat), .ovf(ovf_sat)
    );

    counter_updown_param #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .RESET_VALUE(5)) u_rst (
        .clk(clk), .reset(reset), .count_enb(count_enb), .up_dn(up_dn), .load(load),
        .load_value(load_value), .ovf_clr(ovf_clr), .count(count_rst), .tc(tc_rst), .ovf(ovf_rst)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        count_enb  = 1'b0;
        up_dn      = 1'b1;
        load       = 1'b0;
        load_value = 8'd0;
        ovf_clr    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b0;
        // Down-step at 0 would raise tc if reset did not mask it.
        count_enb = 1'b1;
        up_dn     = 1'b0;
        repeat (3) tick();
        #1;
        n_tests++;
        if (count_def !== 8'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", count_def);
        end
        n_tests++;
        if (ovf_def !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %0b expected 0", ovf_def);
        end
        n_tests++;
        if (tc_def !== 1'b0) begin
            n_fail++; $display("FAIL reset_tc_masked: got %0b expected 0", tc_def);
        end
        n_tests++;
        if (count_rst !== 8'd5) begin
            n_fail++; $display("FAIL reset_value: got %0d expected 5", count_rst);
        end
    endtask

    task automatic test_up_count();
        int         exp_cnt;
        logic       exp_ovf;
        exp_cnt   = 0;
        exp_ovf   = 1'b0;
        reset     = 1'b1;
        count_enb = 1'b1;
        up_dn     = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            n_tests++;
            if (count_def !== 8'(exp_cnt) || tc_def !== (exp_cnt == 255) || ovf_def !== exp_ovf)
            begin
                n_fail++;
                $display("FAIL up_count[%0d]: got cnt=%0d tc=%0b ovf=%0b expected cnt=%0d tc=%0b ovf=%0b",
                         i, count_def, tc_def, ovf_def, exp_cnt, (exp_cnt == 255), exp_ovf);
            end
            tick();
            if (exp_cnt == 255) begin
                exp_cnt = 0;
                exp_ovf = 1'b1;
            end else begin
                exp_cnt = exp_cnt + 1;
            end
        end
    endtask

    task automatic test_mod_down();
        logic [3:0] seq [12] = '{4'd0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1,
                                 4'd0, 4'd9};
        do_reset();
        count_enb = 1'b1;
        up_dn     = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_tests++;
            if (count_mod !== seq[i] || tc_mod !== (seq[i] == 4'd0) || count_mod > 4'd9) begin
                n_fail++;
                $display("FAIL mod_down[%0d]: got cnt=%0d tc=%0b expected cnt=%0d tc=%0b",
                         i, count_mod, tc_mod, seq[i], (seq[i] == 4'd0));
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        logic [7:0] seq_cnt [6] = '{8'd253, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255};
        logic       seq_tc  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       seq_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        load       = 1'b1;
        load_value = 8'd253;
        tick();
        load      = 1'b0;
        count_enb = 1'b1;
        up_dn     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++;
            if (count_sat !== seq_cnt[i] || tc_sat !== seq_tc[i] || ovf_sat !== seq_ovf[i]) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got cnt=%0d tc=%0b ovf=%0b expected cnt=%0d tc=%0b ovf=%0b",
                         i, count_sat, tc_sat, ovf_sat, seq_cnt[i], seq_tc[i], seq_ovf[i]);
            end
            tick();
        end
        n_tests++;
        if (count_sat !== 8'd255 || ovf_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_hold: got cnt=%0d ovf=%0b expected cnt=255 ovf=1",
                     count_sat, ovf_sat);
        end
    endtask

    task automatic test_load_clamp();
        do_reset();
        // Underflow from 0 to set ovf so the loads can be seen not to touch it.
        count_enb = 1'b1;
        up_dn     = 1'b0;
        tick();
        n_tests++;
        if (count_mod !== 4'd9 || ovf_mod !== 1'b1) begin
            n_fail++;
            $display("FAIL load_setup: got cnt=%0d ovf=%0b expected cnt=9 ovf=1", count_mod, ovf_mod);
        end
        load       = 1'b1;
        up_dn      = 1'b1;
        load_value = 8'd7;
        #1;
        n_tests++;
        if (tc_mod !== 1'b0) begin
            n_fail++; $display("FAIL load_masks_tc: got %0b expected 0", tc_mod);
        end
        tick();
        n_tests++;
        if (count_mod !== 4'd7 || ovf_mod !== 1'b1) begin
            n_fail++;
            $display("FAIL load_7: got cnt=%0d ovf=%0b expected cnt=7 ovf=1", count_mod, ovf_mod);
        end
        load_value = 8'd15;
        tick();
        n_tests++;
        if (count_mod !== 4'd9 || ovf_mod !== 1'b1) begin
            n_fail++;
            $display("FAIL load_clamp: got cnt=%0d ovf=%0b expected cnt=9 ovf=1", count_mod, ovf_mod);
        end
        n_tests++;
        if (count_def !== 8'd15) begin
            n_fail++; $display("FAIL load_no_clamp: got %0d expected 15", count_def);
        end
        load = 1'b0;
    endtask

    task automatic test_ovf_collision();
        do_reset();
        load       = 1'b1;
        load_value = 8'd254;
        tick();
        load      = 1'b0;
        count_enb = 1'b1;
        up_dn     = 1'b1;
        tick();
        ovf_clr = 1'b1;
        #1;
        n_tests++;
        if (count_def !== 8'd255 || tc_def !== 1'b1 || ovf_def !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_pre: got cnt=%0d tc=%0b ovf=%0b expected cnt=255 tc=1 ovf=0",
                     count_def, tc_def, ovf_def);
        end
        tick();
        n_tests++;
        if (count_def !== 8'd0 || ovf_def !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_set_wins: got cnt=%0d ovf=%0b expected cnt=0 ovf=1",
                     count_def, ovf_def);
        end
        tick();
        n_tests++;
        if (count_def !== 8'd1 || ovf_def !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got cnt=%0d ovf=%0b expected cnt=1 ovf=0", count_def, ovf_def);
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_direction();
        do_reset();
        load       = 1'b1;
        load_value = 8'd10;
        tick();
        load      = 1'b0;
        count_enb = 1'b1;
        up_dn     = 1'b1;
        tick();
        up_dn = 1'b0;
        tick();
        n_tests++;
        if (count_def !== 8'd10) begin
            n_fail++; $display("FAIL dir_down: got %0d expected 10", count_def);
        end
        up_dn = 1'b1;
        tick();
        n_tests++;
        if (count_def !== 8'd11) begin
            n_fail++; $display("FAIL dir_up: got %0d expected 11", count_def);
        end
        count_enb = 1'b0;
        tick();
        n_tests++;
        if (count_def !== 8'd11) begin
            n_fail++; $display("FAIL hold: got %0d expected 11", count_def);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        // Wrap once so ovf is 1 before the mid-run reset.
        load       = 1'b1;
        load_value = 8'd255;
        tick();
        load      = 1'b0;
        count_enb = 1'b1;
        up_dn     = 1'b1;
        tick();
        load       = 1'b1;
        load_value = 8'd100;
        tick();
        load = 1'b0;
        tick();
        n_tests++;
        if (count_rst !== 8'd101 || ovf_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got cnt=%0d ovf=%0b expected cnt=101 ovf=1", count_rst, ovf_rst);
        end
        reset      = 1'b0;
        load       = 1'b1;
        load_value = 8'd200;
        tick();
        n_tests++;
        if (count_rst !== 8'd5 || ovf_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got cnt=%0d ovf=%0b expected cnt=5 ovf=0", count_rst, ovf_rst);
        end
        reset = 1'b1;
        load  = 1'b0;
        tick();
        n_tests++;
        if (count_rst !== 8'd6) begin
            n_fail++; $display("FAIL mid_resume1: got %0d expected 6", count_rst);
        end
        tick();
        n_tests++;
        if (count_rst !== 8'd7) begin
            n_fail++; $display("FAIL mid_resume2: got %0d expected 7", count_rst);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #1;
        test_reset();
        test_up_count();
        test_mod_down();
        test_saturate();
        test_load_clamp();
        test_ovf_collision();
        test_direction();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
